// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU/op/cond codes,
// mux select values and the data-processing command decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  typedef struct packed {
    logic [1:0] alu_control;
    logic       no_write;
    logic       arith;
  } alu_dec_t;

  // Unrecognised commands run as ADD but never touch C/V.
  function automatic alu_dec_t decode_alu(input logic [3:0] cmd);
    alu_dec_t d;
    d = '{alu_control: ALU_ADD, no_write: 1'b0, arith: 1'b0};
    case (cmd)
      CMD_ADD: begin d.alu_control = ALU_ADD; d.arith = 1'b1; end
      CMD_SUB: begin d.alu_control = ALU_SUB; d.arith = 1'b1; end
      CMD_AND: d.alu_control = ALU_AND;
      CMD_ORR: d.alu_control = ALU_ORR;
      CMD_CMP: begin d.alu_control = ALU_SUB; d.arith = 1'b1; d.no_write = 1'b1; end
      default: d.alu_control = ALU_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// NZCV flag register and condition-code evaluation. CondEx always reflects the
// registered flags, so an update made in one cycle is seen from the next.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  output logic       CondEx
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       n_flag;
  logic       z_flag;
  logic       c_flag;
  logic       v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  always_comb begin
    CondEx = 1'b1;
    case (cond)
      COND_EQ: CondEx = z_flag;
      COND_NE: CondEx = ~z_flag;
      COND_CS: CondEx = c_flag;
      COND_CC: CondEx = ~c_flag;
      COND_MI: CondEx = n_flag;
      COND_PL: CondEx = ~n_flag;
      COND_VS: CondEx = v_flag;
      COND_VC: CondEx = ~v_flag;
      COND_HI: CondEx = c_flag & ~z_flag;
      COND_LS: CondEx = ~c_flag | z_flag;
      COND_GE: CondEx = (n_flag == v_flag);
      COND_LT: CondEx = (n_flag != v_flag);
      COND_GT: CondEx = ~z_flag & (n_flag == v_flag);
      COND_LE: CondEx = z_flag | (n_flag != v_flag);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

  // FlagW[1] loads NZ, FlagW[0] loads CV; a failed condition blocks both.
  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && CondEx) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] && CondEx) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencer for the ARM-subset datapath: FSM, output and ALU decode.
// Optional CTRL_PERF_CNT_EN adds retired-instruction and memory-stall counters.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd_is_pc;
  logic       cond_ex;
  logic [1:0] flag_w;
  alu_dec_t   alu_dec;
  logic       unused_rn;

  logic       pc_write;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] reg_src;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd_is_pc  = (Instr[3:0] == 4'hF);
  assign unused_rn = ^Instr[7:4];
  assign alu_dec   = decode_alu(funct[4:1]);

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .CondEx   (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_WDATA;
    reg_src     = 2'b00;
    flag_w      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          OP_NOP:  state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b   = SRCB_IMM;
        alu_control = funct[3] ? ALU_ADD : ALU_SUB;
        state_d     = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = cond_ex;
        pc_write   = cond_ex & rd_is_pc;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // A suppressed store never starts a bus access, so there is nothing to wait for.
        adr_src   = 1'b1;
        reg_src   = 2'b10;
        mem_write = cond_ex;
        if (!cond_ex || mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_WDATA;
        alu_control = alu_dec.alu_control;
        flag_w      = {funct[0], funct[0] & alu_dec.arith};
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = cond_ex & ~alu_dec.no_write;
        pc_write   = cond_ex & ~alu_dec.no_write & rd_is_pc;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = cond_ex;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are forced low during reset so nothing architectural changes.
  assign PCWrite    = pc_write & ~reset;
  assign MemWrite   = mem_write & ~reset;
  assign IRWrite    = ir_write & ~reset;
  assign RegWrite   = reg_write & ~reset;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUControl = alu_control;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ImmSrc     = op;
  assign RegSrc     = reg_src;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] retired_d;
  logic [31:0] stall_q;
  logic [31:0] stall_d;
  logic        access_stall;

  always_comb begin
    retired_d    = retired_q;
    stall_d      = stall_q;
    access_stall = ~mem_ready &
                   ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                    ((state_q == S_MEMWR) && cond_ex));
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) retired_d = retired_q + 32'd1;
    if (access_stall) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-level reference model queues
// the expected control word of every cycle; a negedge monitor pops and compares.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc)
`ifdef CTRL_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  bit          mr_force[$];
  logic [3:0]  mflags = 4'h0;
  int          m_retired = 0;
  int          m_stall = 0;
  logic [15:0] act;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc};

  always @(negedge clk) begin
    logic [15:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, act, e);
      end
    end
    cyc++;
  end

  // Control word order matches the act concatenation above.
  function automatic logic [15:0] w(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic [1:0] rs, input logic [1:0] alu,
                                    input logic sa, input logic [1:0] sb, input logic [1:0] imm,
                                    input logic rw, input logic [1:0] rsrc);
    return {pcw, adr, mw, irw, rs, alu, sa, sb, imm, rw, rsrc};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit next_mr();
    if (mr_force.size() > 0) return mr_force.pop_front();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic step(input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH; rst_mw injects reset inside MEMWR.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] aflags,
                           input string nm, input bit rst_mw);
    logic [3:0] c, cmd;
    logic [1:0] op, aluc;
    logic [5:0] f;
    bit         ce, mr, rdpc, rw, nowr, arith, retire;
    c      = ins[19:16];
    op     = ins[15:14];
    f      = ins[13:8];
    rdpc   = (ins[3:0] == 4'hF);
    retire = 1'b1;
    Instr  = ins;
    do begin
      mr = next_mr();
      mem_ready = mr;
      ALUFlags = 4'($urandom);
      if (!mr) m_stall++;
      step(w(mr, 0, 0, mr, 2'b10, 2'b00, 1, 2'b10, op, 0, 2'b00), {nm, ".fetch"});
    end while (!mr);
    mem_ready = 1'($urandom);
    ALUFlags = 4'($urandom);
    step(w(0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, op, 0, 2'b00), {nm, ".decode"});
    ce = cond_ok(c, mflags);
    case (op)
      2'b00: begin
        cmd   = f[4:1];
        nowr  = (cmd == 4'b1010);
        arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        if (cmd == 4'b0000)      aluc = 2'b10;
        else if (cmd == 4'b1100) aluc = 2'b11;
        else if (cmd == 4'b0010 || cmd == 4'b1010) aluc = 2'b01;
        else aluc = 2'b00;
        ALUFlags = aflags;
        mem_ready = 1'($urandom);
        step(w(0, 0, 0, 0, 2'b00, aluc, 0, f[5] ? 2'b01 : 2'b00, op, 0, 2'b00), {nm, ".exec"});
        if (ce && f[0]) mflags[3:2] = aflags[3:2];
        if (ce && f[0] && arith) mflags[1:0] = aflags[1:0];
        ce = cond_ok(c, mflags);
        rw = ce && !nowr;
        ALUFlags = 4'($urandom);
        step(w(rw && rdpc, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, op, rw, 2'b00), {nm, ".aluwb"});
      end
      2'b01: begin
        mem_ready = 1'($urandom);
        step(w(0, 0, 0, 0, 2'b00, f[3] ? 2'b00 : 2'b01, 0, 2'b01, op, 0, 2'b00), {nm, ".memadr"});
        if (f[0]) begin
          do begin
            mr = next_mr();
            mem_ready = mr;
            if (!mr) m_stall++;
            step(w(0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, op, 0, 2'b00), {nm, ".memrd"});
          end while (!mr);
          mem_ready = 1'($urandom);
          step(w(ce && rdpc, 0, 0, 0, 2'b01, 2'b00, 0, 2'b00, op, ce, 2'b00), {nm, ".memwb"});
        end else if (rst_mw) begin
          mem_ready = 1'b0;
          if (ce) m_stall++;
          step(w(0, 1, ce, 0, 2'b00, 2'b00, 0, 2'b00, op, 0, 2'b10), {nm, ".memwr"});
          reset = 1'b1;
          step(w(0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, op, 0, 2'b10), {nm, ".memwr_rst"});
          reset = 1'b0;
          mflags = 4'h0;
          m_retired = 0;
          m_stall = 0;
          retire = 1'b0;
        end else begin
          do begin
            mr = next_mr();
            mem_ready = mr;
            if (ce && !mr) m_stall++;
            step(w(0, 1, ce, 0, 2'b00, 2'b00, 0, 2'b00, op, 0, 2'b10), {nm, ".memwr"});
          end while (ce && !mr);
        end
      end
      2'b10: begin
        mem_ready = 1'($urandom);
        step(w(ce, 0, 0, 0, 2'b10, 2'b00, 0, 2'b01, op, 0, 2'b00), {nm, ".branch"});
      end
      default: ;
    endcase
    if (retire) m_retired++;
    $display("[TB] %-8s instr=%h cond_ex=%0d flags=%h", nm, ins, ce, mflags);
`ifdef CTRL_PERF_CNT_EN
    tests += 2;
    if (retired_cnt !== 32'(m_retired)) begin
      fails++;
      $display("FAIL retired_cnt got=%0d required=%0d", retired_cnt, m_retired);
    end
    if (stall_cnt !== 32'(m_stall)) begin
      fails++;
      $display("FAIL stall_cnt got=%0d required=%0d", stall_cnt, m_stall);
    end
`endif
  endtask

  function automatic logic [19:0] rand_instr();
    logic [3:0] c, rd, cmd;
    logic [1:0] op;
    logic [5:0] f;
    int         pick;
    c  = 4'($urandom_range(0, 14));
    op = 2'($urandom);
    f  = 6'($urandom);
    rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    if (op == 2'b00) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        4: cmd = 4'b1010;
        default: cmd = 4'b0001;
      endcase
      f[4:1] = cmd;
      if (pick == 5) f[0] = 1'b0;
    end
    return {c, op, f, 4'($urandom), rd};
  endfunction

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      mem_ready = 1'b1;
      step(w(0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, Instr[15:14], 0, 2'b00), "reset");
    end
    reset = 1'b0;
    mflags = 4'h0;

    mr_force = '{1'b1};
    run_instr(20'hE0921, 4'b0100, "ADDS", 1'b0);
    run_instr(20'hE1510, 4'b0100, "CMP_z1", 1'b0);
    run_instr(20'h0A000, 4'h0, "BEQ_tk", 1'b0);
    run_instr(20'hE1510, 4'b0000, "CMP_z0", 1'b0);
    run_instr(20'h0A000, 4'h0, "BEQ_nt", 1'b0);
    mr_force = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_instr(20'hE5921, 4'h0, "LDR_w2", 1'b0);
    run_instr(20'hE1510, 4'b0100, "CMP_z1", 1'b0);
    mr_force = '{1'b1, 1'b0};
    run_instr(20'h15801, 4'h0, "STRNE", 1'b0);
    mr_force = '{1'b1};
    run_instr(20'hE5801, 4'h0, "STR_rst", 1'b1);
    run_instr(20'h0A000, 4'h0, "BEQ_clr", 1'b0);
    run_instr(20'h5A000, 4'h0, "BPL_clr", 1'b0);

    for (int i = 0; i < 200; i++) begin
      run_instr(rand_instr(), 4'($urandom), $sformatf("rnd%0d", i), 1'b0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
